// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Turns the PLL lock status of the clock generator into ordered synchronous
// resets for the pixel-clock domain. The core domain leaves reset after lock
// has been stable for STABLE_CYCLES cycles. The video domain follows
// STAGE_GAP cycles later. Any lock loss after the core release forces both
// domains back into reset, pulses lock_lost and bumps a saturating counter.
//
// Ports:
//   clk        in   pixel clock (clk65MHz)
//   rst        in   synchronous active-high reset
//   locked     in   PLL lock status, asynchronous to clk
//   rst_core   out  active-high reset for core logic
//   rst_video  out  active-high reset for video timing/drawing
//   ready      out  high when both domains are out of reset
//   lock_lost  out  one-cycle pulse on a lock loss after core release
//   loss_count out  saturating count of lock losses (cleared only by rst)
//   state      out  current FSM state (debug visibility)
//
// Handshake note: there is no valid/ready traffic here. The outputs are
// level signals that change only on a clk edge. lock_lost is a single-cycle
// strobe with no back-pressure.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    output logic             rst_core,
    output logic             rst_video,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int MAX_TERM = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int CW       = $clog2(MAX_TERM) + 1;

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK    = 2'd0,
        STABILIZE    = 2'd1,
        RELEASE_CORE = 2'd2,
        RUN          = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          loss_nxt;

    // Two-flop synchronizer. Only s2 is used by the rest of the block.
    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= locked;
            s2 <= s1;
        end
    end

    // Next-state logic. A lock loss is checked before counter expiry so a
    // dropout coinciding with the terminal count still returns to WAIT_LOCK.
    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = cnt;
        loss_nxt  = 1'b0;
        case (cur_state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (s2) begin
                    nxt_state = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!s2) begin
                    // Dropout before release is not a counted loss.
                    nxt_state = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    nxt_state = RELEASE_CORE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE_CORE: begin
                if (!s2) begin
                    nxt_state = WAIT_LOCK;
                    cnt_nxt   = '0;
                    loss_nxt  = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    nxt_state = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!s2) begin
                    nxt_state = WAIT_LOCK;
                    loss_nxt  = 1'b1;
                end
            end
            default: begin
                nxt_state = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register plus registered decodes of the next state, so every
    // output is a flop and cannot glitch between clock edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= WAIT_LOCK;
            cnt        <= '0;
            rst_core   <= 1'b1;
            rst_video  <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            rst_core  <= (nxt_state == WAIT_LOCK) || (nxt_state == STABILIZE);
            rst_video <= (nxt_state != RUN);
            ready     <= (nxt_state == RUN);
            lock_lost <= loss_nxt;
            if (loss_nxt && (loss_count != {CNT_W{1'b1}})) begin
                loss_count <= loss_count + CNT_W'(1);
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with STABLE_CYCLES=8, STAGE_GAP=4 and
// CNT_W=2. Expected output vectors {rst_core, rst_video, ready, lock_lost,
// loss_count} are derived from the edge-relative release/loss timing and
// queued before the clock edges they describe. They are then popped and
// compared one per edge, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int SC   = 8;
  localparam int GAP  = 4;
  localparam int CW   = 2;
  localparam int REL  = 3 + SC + GAP;   // edges from lock rise to full release
  localparam int CREL = 3 + SC;         // edges from lock rise to core release
  localparam int W    = 5 + CW;

  logic          clk;
  logic          rst;
  logic          locked;
  logic          rst_core;
  logic          rst_video;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] loss_count;
  logic [1:0]    state;

  logic [W-1:0]  exp_q[$];
  int            checks;
  int            failures;

  reset_sequencer #(
    .STABLE_CYCLES(SC),
    .STAGE_GAP(GAP),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .rst_core(rst_core),
    .rst_video(rst_video),
    .ready(ready),
    .lock_lost(lock_lost),
    .loss_count(loss_count),
    .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pack(input logic c, input logic v, input logic r,
                                        input logic l, input logic [CW-1:0] n);
    return {c, v, r, l, n};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] n);
    return (n == {CW{1'b1}}) ? n : n + CW'(1);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic drain(input int n, input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = {rst_core, rst_video, ready, lock_lost, loss_count};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s observed=%b expected=<empty queue>", tag, obs);
      end else begin
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
          failures++;
          $error("FAIL %s edge=%0d observed=%b expected=%b", tag, i + 1, obs, exp);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Lock rises before edge 1 (or was already high with the synchronizer just
  // cleared). Queues edges 1..last of the release timeline.
  task automatic push_release(input logic [CW-1:0] n, input int last);
    for (int k = 1; k <= last; k++) begin
      exp_q.push_back(pack(k < CREL, k < REL, k >= REL, 1'b0, n));
    end
  endtask

  task automatic hold(input int cycles, input logic [W-1:0] v, input string tag);
    for (int i = 0; i < cycles; i++) exp_q.push_back(v);
    drain(cycles, tag);
  endtask

  // Drop lock before edge 1 while outputs show {c,v,r}. The synchronizer
  // delays the FSM reaction to edge 3.
  task automatic lose(input logic c, input logic v, input logic r,
                      input logic [CW-1:0] n, input string tag);
    locked = 1'b0;
    exp_q.push_back(pack(c, v, r, 1'b0, n));
    exp_q.push_back(pack(c, v, r, 1'b0, n));
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b1, sat_inc(n)));
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, sat_inc(n)));
    drain(4, tag);
  endtask

  task automatic full_release(input logic [CW-1:0] n, input string tag);
    locked = 1'b1;
    push_release(n, REL);
    drain(REL, tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    locked   = 1'b0;

    // Reset state
    hold(2, pack(1'b1, 1'b1, 1'b0, 1'b0, '0), "reset_values");
    checks++;
    assert (state === 2'd0) else begin
      failures++;
      $error("FAIL reset_state observed=%0d expected=0", state);
    end

    // Dropout during STABILIZE: lock 6 edges, drop 3, then full restart
    rst    = 1'b0;
    locked = 1'b1;
    hold(6, pack(1'b1, 1'b1, 1'b0, 1'b0, '0), "stabilize_partial");
    locked = 1'b0;
    hold(3, pack(1'b1, 1'b1, 1'b0, 1'b0, '0), "stabilize_dropout");
    full_release(2'd0, "release_after_dropout");
    hold(3, pack(1'b0, 1'b0, 1'b1, 1'b0, 2'd0), "run_steady0");

    // Loss in RUN, then re-lock with identical latency
    lose(1'b0, 1'b0, 1'b1, 2'd0, "loss_in_run1");
    hold(2, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd1), "wait_after_loss1");
    full_release(2'd1, "relock_release1");
    lose(1'b0, 1'b0, 1'b1, 2'd1, "loss_in_run2");
    full_release(2'd2, "relock_release2");
    hold(2, pack(1'b0, 1'b0, 1'b1, 1'b0, 2'd2), "run_steady2");

    // Reset mid-operation in RUN with loss_count=2, locked held high
    rst = 1'b1;
    hold(1, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd0), "reset_mid_run");
    rst = 1'b0;
    push_release(2'd0, REL);
    drain(REL, "release_after_reset");

    // Loss in RELEASE_CORE: lock drops after edge 12, coinciding with the
    // edge where the stage gap would otherwise expire -- video stays in reset.
    lose(1'b0, 1'b0, 1'b1, 2'd0, "loss_before_core_test");
    locked = 1'b1;
    push_release(2'd1, CREL + 1);
    drain(CREL + 1, "core_release_partial");
    lose(1'b0, 1'b1, 1'b0, 2'd1, "loss_in_release_core");

    // Saturation: further losses count 3, 3, 3
    full_release(2'd2, "sat_release_a");
    lose(1'b0, 1'b0, 1'b1, 2'd2, "sat_loss_a");
    full_release(2'd3, "sat_release_b");
    lose(1'b0, 1'b0, 1'b1, 2'd3, "sat_loss_b");
    full_release(2'd3, "sat_release_c");
    lose(1'b0, 1'b0, 1'b1, 2'd3, "sat_loss_c");
    hold(3, pack(1'b1, 1'b1, 1'b0, 1'b0, 2'd3), "sat_hold");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the `locked` status of `clock_generator` and produces ordered, glitch-free synchronous resets for logic running on the generated pixel clock. It sits directly after `clock_generator`, is clocked by `clk65MHz`, and is the sole reset source for the core and video domains. Core logic leaves reset first; the video timing chain follows `STAGE_GAP` cycles later. Lock losses are detected, counted and force both domains back into reset.

## Interface
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release; ≥1.
- `STAGE_GAP`, 16: cycles between `rst_core` release and `rst_video` release; ≥1.
- `CNT_W`, 8: width of `loss_count`.

- `clk`  in  1  generated pixel clock (`clk65MHz`).
- `rst`  in  1  synchronous, active-high reset.
- `locked`  in  1  PLL lock status; asynchronous to `clk`.
- `rst_core`  out  1  active-high reset for core logic.
- `rst_video`  out  1  active-high reset for video timing/drawing.
- `ready`  out  1  high when both domains are out of reset.
- `lock_lost`  out  1  one-cycle pulse on lock loss after release.
- `loss_count`  out  CNT_W  saturating count of lock losses.

## Operation
- Input sync: `locked` passes through two flops (`s1`, `s2`); FSM uses only `s2`. No other logic sees raw `locked`.
- FSM states: WAIT_LOCK, STABILIZE, RELEASE_CORE, RUN.
  - WAIT_LOCK: `s2`=1 → STABILIZE, stability counter cleared to 0.
  - STABILIZE: counter +1 per cycle while `s2`=1. When counter == `STABLE_CYCLES`-1 → RELEASE_CORE, counter cleared. `s2`=0 → WAIT_LOCK, counter cleared, not a counted loss.
  - RELEASE_CORE: counter +1 per cycle. When counter == `STAGE_GAP`-1 → RUN.
  - RUN: steady state.
  - In RELEASE_CORE or RUN, `s2`=0 takes priority over counter expiry → WAIT_LOCK, `lock_lost` pulses, `loss_count` increments.
- Outputs are registered state decodes:
  - `rst_core` = 1 in WAIT_LOCK/STABILIZE.
  - `rst_video` = 1 in every state except RUN.
  - `ready` = RUN.
- `loss_count` saturates at 2^CNT_W−1 and never wraps. Only `rst` clears it.
- Counter width is clog2(max(`STABLE_CYCLES`,`STAGE_GAP`))+1. Counter never exceeds its terminal value.

## Timing
- Reset values (after `rst` edge): `s1`=`s2`=0, state WAIT_LOCK, counter 0, `rst_core`=1, `rst_video`=1, `ready`=0, `lock_lost`=0, `loss_count`=0.
- `rst` mid-operation returns to these values on the next edge regardless of state. `rst` overrides a simultaneous lock loss, so there is no pulse and no count.
- Let `locked` rise before edge 1, with `s2` high after edge 2:
  - STABILIZE after edge 3.
  - `rst_core` low after edge 3+`STABLE_CYCLES`.
  - `rst_video` low and `ready` high after edge 3+`STABLE_CYCLES`+`STAGE_GAP`.
- Let `locked` fall before edge n:
  - `s2` low after edge n+1.
  - After edge n+2: both resets high, `ready` low, `lock_lost`=1 for exactly one cycle, `loss_count` updated.
- `locked` pulses shorter than one `clk` period may be missed. A dropout visible in `s2` during STABILIZE fully restarts the stability count.
- Resets never glitch: each output changes only on a `clk` edge, and at most once per state transition.

## Test plan
- Power-up release: `STABLE_CYCLES`=8, `STAGE_GAP`=4, `rst` released, `locked` high before edge 1 → `rst_core` falls after edge 11; `rst_video` falls and `ready` rises after edge 15. `loss_count`=0 and `lock_lost` never pulses.
- Dropout during STABILIZE: same parameters, `locked` low for 3 cycles mid-count, then high → full 8-cycle count restarts from re-entry. `loss_count` stays 0 and there is no `lock_lost` pulse.
- Loss in RUN: from RUN, drop `locked` before edge n → after edge n+2 both resets are 1, `ready`=0, a single-cycle `lock_lost` pulse occurs and `loss_count`=1. Re-lock → the release sequence repeats with identical latency.
- Loss in RELEASE_CORE: drop `locked` 2 cycles after `rst_core` falls → `rst_video` is never released, `rst_core` re-asserts and `loss_count` increments.
- Saturation: `CNT_W`=2, six lock/release/loss cycles → `loss_count` sequence 1, 2, 3, 3, 3, 3. `lock_lost` still pulses on every loss.
- Reset mid-operation: assert `rst` for 1 cycle in RUN with `loss_count`=2 → all outputs return to reset values after that edge. With `locked` held high, release completes again after 3+`STABLE_CYCLES`+`STAGE_GAP` edges.
